// File: rtl/mul_q_pkg.sv
// Shared definitions for the pipelined Q-format multiplier: rounding modes and saturation bounds.
// Latency: none (constants and constant functions only).
// Backpressure: not applicable.
package mul_q_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'b00;
    localparam logic [1:0] RND_HALF_UP   = 2'b01;
    localparam logic [1:0] RND_HALF_EVEN = 2'b10;

    // Wide enough for any rounding-path width a real instance will use.
    localparam int BOUND_W = 256;

    // Largest value representable in a w-bit two's complement word, sign-extended.
    function automatic logic signed [BOUND_W-1:0] sat_hi(input int w);
        logic signed [BOUND_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one <<< (w - 1)) - one;
    endfunction

    // Smallest value representable in a w-bit two's complement word, sign-extended.
    function automatic logic signed [BOUND_W-1:0] sat_lo(input int w);
        logic signed [BOUND_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return -(one <<< (w - 1));
    endfunction

endpackage

// File: rtl/q_round_sat.sv
// Rounds a full-width signed product back to Q(W-FRAC).FRAC and saturates or wraps on overflow.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module q_round_sat
    import mul_q_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int SAT  = 1
) (
    input  logic signed [2*W-1:0] p,
    input  logic [1:0]            rnd_mode,
    output logic [W-1:0]          y,
    output logic                  ovf
);

    // One extra bit over the shifted product so the +1 increment can never wrap.
    localparam int RW = 2*W - FRAC + 1;
    localparam logic signed [RW-1:0] Y_MAX = RW'(sat_hi(W));
    localparam logic signed [RW-1:0] Y_MIN = RW'(sat_lo(W));

    logic signed [RW-1:0] q_ext;
    logic signed [RW-1:0] rounded;
    logic [FRAC-1:0]      r;
    logic [FRAC-1:0]      r_low;
    logic                 r_low_nz;
    logic                 inc;

    // Floor shift, rounding increment, range check and clamp.
    always_comb begin
        q_ext    = {p[2*W-1], p[2*W-1:FRAC]};
        r        = p[FRAC-1:0];
        // Remainder bits below the half-LSB weight: nonzero means r is strictly above or below half.
        r_low           = r;
        r_low[FRAC-1]   = 1'b0;
        r_low_nz        = |r_low;
        inc = 1'b0;
        case (rnd_mode)
            RND_HALF_UP:   inc = r[FRAC-1];
            RND_HALF_EVEN: inc = r[FRAC-1] & (r_low_nz | q_ext[0]);
            default:       inc = 1'b0;
        endcase
        rounded = q_ext + {{(RW-1){1'b0}}, inc};
        ovf     = (rounded > Y_MAX) || (rounded < Y_MIN);
        y       = rounded[W-1:0];
        if ((SAT != 0) && ovf) begin
            y = rounded[RW-1] ? Y_MIN[W-1:0] : Y_MAX[W-1:0];
        end
    end

endmodule

// File: rtl/mul_q_pipe.sv
// Pipelined signed Q-format multiplier with selectable rounding, saturation, tag passthrough and sticky overflow.
// Latency: exactly STAGES cycles (1..3) from acceptance to out_valid when not stalled.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module mul_q_pipe
    import mul_q_pkg::*;
#(
    parameter int W      = 32,
    parameter int FRAC   = 16,
    parameter int STAGES = 3,
    parameter int SAT    = 1,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       rnd_mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic [TAG_W-1:0] tag_out,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             clr_ovf
);

    logic en;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // Multiplier operands, either registered or straight from the ports.
    logic [W-1:0]     m_a;
    logic [W-1:0]     m_b;
    logic [1:0]       m_mode;
    logic [TAG_W-1:0] m_tag;
    logic             m_vld;

    generate
        if (STAGES == 3) begin : g_opreg
            logic [W-1:0]     a_q;
            logic [W-1:0]     b_q;
            logic [1:0]       mode_q;
            logic [TAG_W-1:0] tag_q;
            logic             vld_q;

            // Operand register: captures the accepted pair with its mode and tag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    a_q    <= '0;
                    b_q    <= '0;
                    mode_q <= RND_TRUNC;
                    tag_q  <= '0;
                end else if (en) begin
                    vld_q <= in_valid;
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= rnd_mode;
                        tag_q  <= tag_in;
                    end
                end
            end

            assign m_a    = a_q;
            assign m_b    = b_q;
            assign m_mode = mode_q;
            assign m_tag  = tag_q;
            assign m_vld  = vld_q;
        end else begin : g_no_opreg
            assign m_a    = a;
            assign m_b    = b;
            assign m_mode = rnd_mode;
            assign m_tag  = tag_in;
            assign m_vld  = in_valid;
        end
    endgenerate

    logic signed [2*W-1:0] m_a_ext;
    logic signed [2*W-1:0] m_b_ext;
    logic signed [2*W-1:0] p_c;

    assign m_a_ext = {{W{m_a[W-1]}}, m_a};
    assign m_b_ext = {{W{m_b[W-1]}}, m_b};
    assign p_c     = m_a_ext * m_b_ext;

    // Product feeding the rounding stage, either registered or combinational.
    logic signed [2*W-1:0] rs_p;
    logic [1:0]            rs_mode;
    logic [TAG_W-1:0]      rs_tag;
    logic                  rs_vld;

    generate
        if (STAGES >= 2) begin : g_preg
            logic signed [2*W-1:0] p_q;
            logic [1:0]            mode_q;
            logic [TAG_W-1:0]      tag_q;
            logic                  vld_q;

            // Product register: full 2W-bit product travels with its mode and tag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    p_q    <= '0;
                    mode_q <= RND_TRUNC;
                    tag_q  <= '0;
                end else if (en) begin
                    vld_q <= m_vld;
                    if (m_vld) begin
                        p_q    <= p_c;
                        mode_q <= m_mode;
                        tag_q  <= m_tag;
                    end
                end
            end

            assign rs_p    = p_q;
            assign rs_mode = mode_q;
            assign rs_tag  = tag_q;
            assign rs_vld  = vld_q;
        end else begin : g_no_preg
            assign rs_p    = p_c;
            assign rs_mode = m_mode;
            assign rs_tag  = m_tag;
            assign rs_vld  = m_vld;
        end
    endgenerate

    logic [W-1:0] rs_y;
    logic         rs_ovf;

    q_round_sat #(
        .W    (W),
        .FRAC (FRAC),
        .SAT  (SAT)
    ) u_round_sat (
        .p        (rs_p),
        .rnd_mode (rs_mode),
        .y        (rs_y),
        .ovf      (rs_ovf)
    );

    // Output register: holds the result until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            tag_out   <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= rs_vld;
            if (rs_vld) begin
                y       <= rs_y;
                tag_out <= rs_tag;
                ovf     <= rs_ovf;
            end
        end
    end

    // Sticky overflow: a delivered overflowing result beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_q_pipe.sv
module tb_mul_q_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  rnd_mode = 2'b00;
    logic [7:0]  tag_in = '0;
    logic        out_ready = 1'b1;
    logic        clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    // STAGES=3 SAT=1
    logic r3_rdy, r3_vld, r3_ovf, r3_sticky;
    logic [31:0] r3_y;
    logic [7:0]  r3_tag;
    // STAGES=3 SAT=0
    logic w3_rdy, w3_vld, w3_ovf, w3_sticky;
    logic [31:0] w3_y;
    logic [7:0]  w3_tag;
    // STAGES=2 SAT=1
    logic r2_rdy, r2_vld, r2_ovf, r2_sticky;
    logic [31:0] r2_y;
    logic [7:0]  r2_tag;
    // STAGES=1 SAT=1
    logic r1_rdy, r1_vld, r1_ovf, r1_sticky;
    logic [31:0] r1_y;
    logic [7:0]  r1_tag;

    mul_q_pipe #(.W(32), .FRAC(16), .STAGES(3), .SAT(1), .TAG_W(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r3_rdy), .a(a), .b(b),
        .rnd_mode(rnd_mode), .tag_in(tag_in), .out_valid(r3_vld), .out_ready(out_ready),
        .y(r3_y), .tag_out(r3_tag), .ovf(r3_ovf), .ovf_sticky(r3_sticky), .clr_ovf(clr_ovf));

    mul_q_pipe #(.W(32), .FRAC(16), .STAGES(3), .SAT(0), .TAG_W(8)) u3w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w3_rdy), .a(a), .b(b),
        .rnd_mode(rnd_mode), .tag_in(tag_in), .out_valid(w3_vld), .out_ready(out_ready),
        .y(w3_y), .tag_out(w3_tag), .ovf(w3_ovf), .ovf_sticky(w3_sticky), .clr_ovf(clr_ovf));

    mul_q_pipe #(.W(32), .FRAC(16), .STAGES(2), .SAT(1), .TAG_W(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2_rdy), .a(a), .b(b),
        .rnd_mode(rnd_mode), .tag_in(tag_in), .out_valid(r2_vld), .out_ready(out_ready),
        .y(r2_y), .tag_out(r2_tag), .ovf(r2_ovf), .ovf_sticky(r2_sticky), .clr_ovf(clr_ovf));

    mul_q_pipe #(.W(32), .FRAC(16), .STAGES(1), .SAT(1), .TAG_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1_rdy), .a(a), .b(b),
        .rnd_mode(rnd_mode), .tag_in(tag_in), .out_valid(r1_vld), .out_ready(out_ready),
        .y(r1_y), .tag_out(r1_tag), .ovf(r1_ovf), .ovf_sticky(r1_sticky), .clr_ovf(clr_ovf));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated transaction through all four pipes; checks per-depth latency and result.
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [1:0] mode, input logic [7:0] tg,
                          input logic [31:0] exp_sat, input logic [31:0] exp_wrap,
                          input logic exp_ovf, input logic clr_at_out);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tbv; rnd_mode = mode; tag_in = tg;
        checks++; if (r3_rdy !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b want 1", name, r3_rdy); end
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            clr_ovf = clr_at_out && (i == 3);
            if (i == 1) begin
                checks++; if (r1_vld !== 1'b1) begin errors++; $display("FAIL %s s1 valid: got %b want 1", name, r1_vld); end
                checks++; if (r1_y !== exp_sat) begin errors++; $display("FAIL %s s1 y: got %h want %h", name, r1_y, exp_sat); end
                checks++; if (r1_ovf !== exp_ovf) begin errors++; $display("FAIL %s s1 ovf: got %b want %b", name, r1_ovf, exp_ovf); end
                checks++; if (r1_tag !== tg) begin errors++; $display("FAIL %s s1 tag: got %h want %h", name, r1_tag, tg); end
                checks++; if (r3_vld !== 1'b0) begin errors++; $display("FAIL %s s3 early valid@1: got %b want 0", name, r3_vld); end
            end else if (i == 2) begin
                checks++; if (r2_vld !== 1'b1) begin errors++; $display("FAIL %s s2 valid: got %b want 1", name, r2_vld); end
                checks++; if (r2_y !== exp_sat) begin errors++; $display("FAIL %s s2 y: got %h want %h", name, r2_y, exp_sat); end
                checks++; if (r2_ovf !== exp_ovf) begin errors++; $display("FAIL %s s2 ovf: got %b want %b", name, r2_ovf, exp_ovf); end
                checks++; if (r2_tag !== tg) begin errors++; $display("FAIL %s s2 tag: got %h want %h", name, r2_tag, tg); end
                checks++; if (r1_vld !== 1'b0) begin errors++; $display("FAIL %s s1 valid@2: got %b want 0", name, r1_vld); end
                checks++; if (r3_vld !== 1'b0) begin errors++; $display("FAIL %s s3 early valid@2: got %b want 0", name, r3_vld); end
            end else if (i == 3) begin
                checks++; if (r3_vld !== 1'b1) begin errors++; $display("FAIL %s s3 valid: got %b want 1", name, r3_vld); end
                checks++; if (r3_y !== exp_sat) begin errors++; $display("FAIL %s s3 y: got %h want %h", name, r3_y, exp_sat); end
                checks++; if (r3_ovf !== exp_ovf) begin errors++; $display("FAIL %s s3 ovf: got %b want %b", name, r3_ovf, exp_ovf); end
                checks++; if (r3_tag !== tg) begin errors++; $display("FAIL %s s3 tag: got %h want %h", name, r3_tag, tg); end
                checks++; if (w3_vld !== 1'b1) begin errors++; $display("FAIL %s wrap valid: got %b want 1", name, w3_vld); end
                checks++; if (w3_y !== exp_wrap) begin errors++; $display("FAIL %s wrap y: got %h want %h", name, w3_y, exp_wrap); end
                checks++; if (w3_ovf !== exp_ovf) begin errors++; $display("FAIL %s wrap ovf: got %b want %b", name, w3_ovf, exp_ovf); end
                checks++; if (w3_tag !== tg) begin errors++; $display("FAIL %s wrap tag: got %h want %h", name, w3_tag, tg); end
            end else begin
                checks++; if (r3_vld !== 1'b0) begin errors++; $display("FAIL %s s3 valid@4: got %b want 0", name, r3_vld); end
            end
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (r3_vld !== 1'b0) begin errors++; $display("FAIL reset out_valid in rst: got %b want 0", r3_vld); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (r3_vld !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", r3_vld); end
        checks++; if (r3_y !== 32'h0) begin errors++; $display("FAIL reset y: got %h want 0", r3_y); end
        checks++; if (r3_tag !== 8'h0) begin errors++; $display("FAIL reset tag_out: got %h want 0", r3_tag); end
        checks++; if (r3_ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", r3_ovf); end
        checks++; if (r3_sticky !== 1'b0) begin errors++; $display("FAIL reset ovf_sticky: got %b want 0", r3_sticky); end
        checks++; if ({r3_rdy, w3_rdy, r2_rdy, r1_rdy} !== 4'hF) begin errors++; $display("FAIL reset in_ready: got %b want 1111", {r3_rdy, w3_rdy, r2_rdy, r1_rdy}); end
    endtask

    task automatic test_basic();
        run_op("basic", 32'h0001_8000, 32'h0002_0000, 2'b00, 8'h11, 32'h0003_0000, 32'h0003_0000, 1'b0, 1'b0);
        run_op("maxpos", 32'h7FFF_FFFF, 32'h0001_0000, 2'b00, 8'h12, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_rounding();
        run_op("half_m0", 32'h1, 32'h8000, 2'b00, 8'h21, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op("half_m1", 32'h1, 32'h8000, 2'b01, 8'h22, 32'h1, 32'h1, 1'b0, 1'b0);
        run_op("half_m2", 32'h1, 32'h8000, 2'b10, 8'h23, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op("1p5_m1", 32'h3, 32'h8000, 2'b01, 8'h24, 32'h2, 32'h2, 1'b0, 1'b0);
        run_op("1p5_m2", 32'h3, 32'h8000, 2'b10, 8'h25, 32'h2, 32'h2, 1'b0, 1'b0);
        run_op("1p5_m3", 32'h3, 32'h8000, 2'b11, 8'h26, 32'h1, 32'h1, 1'b0, 1'b0);
        run_op("0p75_m2", 32'h1, 32'hC000, 2'b10, 8'h27, 32'h1, 32'h1, 1'b0, 1'b0);
        run_op("0p75_m0", 32'h1, 32'hC000, 2'b00, 8'h28, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_negative();
        run_op("neg_m0", 32'hFFFF_FFFF, 32'h8000, 2'b00, 8'h31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("neg_m1", 32'hFFFF_FFFF, 32'h8000, 2'b01, 8'h32, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op("neg_m2", 32'hFFFF_FFFF, 32'h8000, 2'b10, 8'h33, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op("negm1p5_m2", 32'hFFFF_FFFD, 32'h8000, 2'b10, 8'h34, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("negm1p5_m1", 32'hFFFF_FFFD, 32'h8000, 2'b01, 8'h35, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++; if (r3_sticky !== 1'b0) begin errors++; $display("FAIL sticky before ovf: got %b want 0", r3_sticky); end
    endtask

    task automatic test_saturation();
        run_op("sat_pos", 32'h7FFF_0000, 32'h0002_0000, 2'b00, 8'h41, 32'h7FFF_FFFF, 32'hFFFE_0000, 1'b1, 1'b0);
        checks++; if ({r3_sticky, w3_sticky, r2_sticky, r1_sticky} !== 4'hF) begin errors++; $display("FAIL sticky after ovf: got %b want 1111", {r3_sticky, w3_sticky, r2_sticky, r1_sticky}); end
        run_op("sat_minsq", 32'h8000_0000, 32'h8000_0000, 2'b00, 8'h42, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
        run_op("sat_neg", 32'h8000_0000, 32'h0002_0000, 2'b01, 8'h43, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_clr_ovf();
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        checks++; if ({r3_sticky, w3_sticky} !== 2'b00) begin errors++; $display("FAIL clr sticky: got %b want 00", {r3_sticky, w3_sticky}); end
        run_op("clr_same", 32'h7FFF_0000, 32'h0002_0000, 2'b00, 8'h51, 32'h7FFF_FFFF, 32'hFFFE_0000, 1'b1, 1'b1);
        checks++; if ({r3_sticky, w3_sticky} !== 2'b11) begin errors++; $display("FAIL set beats clr: got %b want 11", {r3_sticky, w3_sticky}); end
        checks++; if ({r2_sticky, r1_sticky} !== 2'b00) begin errors++; $display("FAIL clr after earlier set: got %b want 00", {r2_sticky, r1_sticky}); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcv = 0;
        logic held = 1'b0;
        logic [31:0] held_y = '0;
        logic [7:0]  held_tag = '0;
        logic [31:0] exp_y;
        apply_reset();
        for (int c = 0; c < 80 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c < 11);
            #1;
            if (r3_vld && out_ready) begin
                exp_y = 32'((2 * rcv + 2) << 16);
                checks++; if (r3_y !== exp_y) begin errors++; $display("FAIL bp y[%0d]: got %h want %h", rcv, r3_y, exp_y); end
                checks++; if (r3_tag !== 8'(rcv)) begin errors++; $display("FAIL bp tag[%0d]: got %h want %h", rcv, r3_tag, 8'(rcv)); end
                rcv++;
                held = 1'b0;
            end else if (r3_vld) begin
                checks++; if (r3_rdy !== 1'b0) begin errors++; $display("FAIL bp in_ready stall: got %b want 0", r3_rdy); end
                if (held) begin
                    checks++; if (r3_y !== held_y) begin errors++; $display("FAIL bp held y: got %h want %h", r3_y, held_y); end
                    checks++; if (r3_tag !== held_tag) begin errors++; $display("FAIL bp held tag: got %h want %h", r3_tag, held_tag); end
                end
                held = 1'b1; held_y = r3_y; held_tag = r3_tag;
            end else begin
                held = 1'b0;
            end
            if (sent < 8) begin
                in_valid = 1'b1;
                a = 32'((sent + 1) << 16);
                b = 32'h0002_0000;
                rnd_mode = 2'b00;
                tag_in = 8'(sent);
                if (r3_rdy) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (rcv !== 8) begin errors++; $display("FAIL bp count: got %0d want 8", rcv); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'((k + 5) << 16); b = 32'h0001_0000; rnd_mode = 2'b00; tag_in = 8'(8'h60 + k);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if ({r3_vld, w3_vld, r2_vld, r1_vld} !== 4'h0) begin errors++; $display("FAIL rst mid valid: got %b want 0000", {r3_vld, w3_vld, r2_vld, r1_vld}); end
        checks++; if (r3_y !== 32'h0) begin errors++; $display("FAIL rst mid y: got %h want 0", r3_y); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if ({r3_vld, w3_vld, r2_vld, r1_vld} !== 4'h0) begin errors++; $display("FAIL rst stale valid %0d: got %b want 0000", k, {r3_vld, w3_vld, r2_vld, r1_vld}); end
        end
        run_op("post_rst", 32'h0002_0000, 32'h0003_0000, 2'b00, 8'h77, 32'h0006_0000, 32'h0006_0000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_negative();
        test_saturation();
        test_clr_ovf();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_q_pipe.md
# mul_q_pipe

Parametrised, pipelined signed fixed-point multiplier: the successor to the fixed Q16 truncating multiplier used in the Horner evaluation datapath. It multiplies two W-bit signed Qm.FRAC operands and produces a W-bit result in the same format. It adds selectable rounding, optional saturation with a sticky overflow flag, a valid/ready handshake with backpressure, and a tag passthrough so the Horner sequencer can track coefficient indices through the pipe.

## Interface

Parameters:
- W, 32, operand and result width in bits.
- FRAC, 16, fraction bits; legal range 1..W-1.
- STAGES, 3, pipeline depth; legal values 1, 2, 3.
- SAT, 1, 1 = saturate on overflow, 0 = wrap (keep the low W bits).
- TAG_W, 8, width of the sideband tag; legal range >= 1.

Ports:
- clk, in, 1, the single clock.
- rst, in, 1, reset; asynchronous, active-high.
- in_valid, in, 1, the operand pair is valid.
- in_ready, out, 1, the block accepts the operand pair this cycle.
- a, in, W, signed multiplicand in Q(W-FRAC).FRAC.
- b, in, W, signed multiplier in Q(W-FRAC).FRAC.
- rnd_mode, in, 2, rounding mode; sampled together with a and b.
- tag_in, in, TAG_W, sideband carried alongside the operands.
- out_valid, out, 1, y and tag_out are valid.
- out_ready, in, 1, the consumer accepts y this cycle.
- y, out, W, signed product in the same Q format as the operands.
- tag_out, out, TAG_W, the tag_in of the operand pair that produced y.
- ovf, out, 1, overflow flag for the current y.
- ovf_sticky, out, 1, set by any accepted result with ovf=1.
- clr_ovf, in, 1, synchronous clear of ovf_sticky.

## Operation

- Full product is p = a*b, 2W bits signed.
- q = p >>> FRAC (arithmetic shift). r = p[FRAC-1:0]. half = 2^(FRAC-1).
- rnd_mode 00, truncate: result = q (floor, legacy behaviour).
- rnd_mode 01, round half up: result = (p + half) >>> FRAC.
- rnd_mode 10, round half even: result = q + 1 if r > half, or if r == half and q[0] = 1; otherwise result = q.
- rnd_mode 11 is reserved and behaves as 00.
- Rounding is computed in 2W-FRAC+1 bits so the increment cannot wrap.
- Overflow: the rounded value lies outside [-2^(W-1), 2^(W-1)-1].
  - SAT=1: clamp to the nearer bound and set ovf=1.
  - SAT=0: y is the low W bits and ovf is still reported.
- ovf_sticky behaviour:
  - It sets when out_valid & out_ready & ovf.
  - It clears on clr_ovf.
  - If set and clear happen in the same cycle, set wins.
- rnd_mode and tag travel with their operand pair through every stage.

## Timing

- Latency is exactly STAGES cycles from acceptance (in_valid & in_ready) to out_valid, assuming no stall.
- Stage split:
  - STAGES=3: operand register, then product register, then round/saturate output register.
  - STAGES=2: product register, then output register.
  - STAGES=1: output register only.
- One valid bit per stage.
- Pipeline enable is en = !out_valid | out_ready. in_ready = en.
- When en=0, every stage register holds its value. No data is dropped, duplicated or reordered.
- Throughput is 1 result per cycle while out_ready=1.
- in_valid=0 inserts a bubble. Bubbles are not collapsed.
- Reset values: all stage valid bits 0, out_valid=0, y=0, tag_out=0, ovf=0, ovf_sticky=0. in_ready=1 after reset.
- Reset asserted mid-operation discards every in-flight transaction. The first accepted input after reset emerges STAGES cycles later.
- Outputs are registered. in_ready is combinational from out_valid and out_ready only.

## Structure

- Shared package mul_q_pkg holds:
  - the rounding-mode constants RND_TRUNC=2'b00, RND_HALF_UP=2'b01, RND_HALF_EVEN=2'b10;
  - a function or localparam helper for the saturation bounds.
- Combinational sub-module q_round_sat. It is parametrised by W, FRAC and SAT, takes p and rnd_mode, and returns y and ovf.
- The top level holds the stage registers, the valid chain and the sticky flag.

## Test plan

- Basic product: W=32, FRAC=16, mode 00, a=0x00018000, b=0x00020000.
  - Expect y=0x00030000 exactly 3 cycles after acceptance, with ovf=0.
- Rounding modes with a=1, b=0x00008000 (p=0x8000, exactly half an LSB):
  - mode 00: y=0.
  - mode 01: y=1.
  - mode 10: y=0.
  - With a=3 (p=1.5 LSB), modes 01 and 10 both give y=2.
- Negative truncation: a=0xFFFFFFFF, b=0x00008000.
  - mode 00: y=0xFFFFFFFF.
  - mode 01: y=0.
- Saturation: a=0x7FFF0000, b=0x00020000.
  - SAT=1: y=0x7FFFFFFF, ovf=1, ovf_sticky=1.
  - SAT=0: y=0xFFFE0000, ovf=1.
  - Also a=b=0x80000000 with SAT=1: expect 0x7FFFFFFF.
  - clr_ovf asserted in the same cycle as a new ovf result leaves ovf_sticky=1.
- Backpressure: stream 8 tagged pairs (tags 0..7) with out_ready low for 5 cycles mid-stream.
  - in_ready drops, and the held y and tag_out stay stable.
  - All 8 results arrive in order with the correct tags.
- Reset mid-stream: assert rst while 3 transactions are in flight.
  - out_valid goes 0 immediately and no stale result ever appears.
  - The next accepted input appears after STAGES cycles.
  - Repeat for STAGES=1 and STAGES=2.
